// File: rtl/rat_intc_pkg.sv
// Shared definitions for the RAT MCU interrupt controller: FSM states, sizes,
// I/O port IDs and the fixed-priority encoder.
package rat_intc_pkg;

  localparam int INTC_MAX_SRC = 8;
  localparam int INTC_ID_W    = 3;

  // IN/OUT port IDs decoded by the MCU port logic to form MASK_WE, EOI and status reads
  localparam logic [7:0] PORT_INTC_MASK_WR = 8'h30;
  localparam logic [7:0] PORT_INTC_EOI_WR  = 8'h31;
  localparam logic [7:0] PORT_INTC_PEND_RD = 8'h30;
  localparam logic [7:0] PORT_INTC_MASK_RD = 8'h31;
  localparam logic [7:0] PORT_INTC_SRC_RD  = 8'h32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_SVC  = 2'd2
  } intc_state_t;

  typedef struct packed {
    logic                 vld;
    logic [INTC_ID_W-1:0] id;
  } intc_prio_t;

  // Lowest set index wins; scanning downward lets the lowest hit overwrite higher ones.
  function automatic intc_prio_t prio_enc(input logic [INTC_MAX_SRC-1:0] req);
    intc_prio_t res;
    res = '0;
    for (int i = INTC_MAX_SRC - 1; i >= 0; i--) begin
      if (req[i]) begin
        res.vld = 1'b1;
        res.id  = i[INTC_ID_W-1:0];
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/intc_edge_detect.sv
// Per-bit rising-edge detector: one-cycle event when a synchronous line goes 0->1.
module intc_edge_detect #(
  parameter int WIDTH = 4
) (
  input  logic             CLK,
  input  logic             RESET_N,
  input  logic [WIDTH-1:0] irq,
  output logic [WIDTH-1:0] evt
);

  logic [WIDTH-1:0] irq_d;

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) irq_d <= '0;
    else          irq_d <= irq;
  end

  assign evt = irq & ~irq_d;

endmodule

// File: rtl/intr_controller.sv
// Multi-source interrupt controller: edge-latched pending bits, software mask,
// fixed-priority grant on acknowledge, single outstanding service until EOI.
module intr_controller
  import rat_intc_pkg::*;
#(
  parameter int N_SRC = 4
) (
  input  logic                  CLK,
  input  logic                  RESET_N,
  input  logic [N_SRC-1:0]      IRQ_IN,
  input  logic                  MASK_WE,
  input  logic [7:0]            MASK_DATA,
  input  logic                  INTR_ACK,
  input  logic                  EOI,
  output logic                  INTR,
  output logic [INTC_ID_W-1:0]  SRC_ID,
  output logic [7:0]            PEND_OUT,
  output logic [7:0]            MASK_OUT
);

  // Bits at or above N_SRC are forced to zero so the registers can stay full width.
  localparam logic [INTC_MAX_SRC-1:0] SRC_MSK = INTC_MAX_SRC'((9'd1 << N_SRC) - 9'd1);

  intc_state_t             state;
  logic [N_SRC-1:0]        evt;
  logic [INTC_MAX_SRC-1:0] evt_ext;
  logic [INTC_MAX_SRC-1:0] pend;
  logic [INTC_MAX_SRC-1:0] mask;
  logic [INTC_MAX_SRC-1:0] cand;
  logic [INTC_MAX_SRC-1:0] clr;
  intc_prio_t              win;
  logic                    grant;

  intc_edge_detect #(.WIDTH(N_SRC)) u_edge (
    .CLK     (CLK),
    .RESET_N (RESET_N),
    .irq     (IRQ_IN),
    .evt     (evt)
  );

  always_comb begin
    evt_ext            = '0;
    evt_ext[N_SRC-1:0] = evt;
  end

  assign cand  = pend & mask;
  assign win   = prio_enc(cand);
  assign grant = (state == ST_REQ) && INTR_ACK && win.vld;
  assign clr   = grant ? (8'd1 << win.id) : '0;

  // A new edge on the bit being granted wins over the clear.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      pend <= '0;
      mask <= '0;
    end else begin
      pend <= (pend & ~clr) | evt_ext;
      if (MASK_WE) mask <= MASK_DATA & SRC_MSK;
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state  <= ST_IDLE;
      INTR   <= 1'b0;
      SRC_ID <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (win.vld) begin
            state <= ST_REQ;
            INTR  <= 1'b1;
          end
        end
        ST_REQ: begin
          if (grant) begin
            SRC_ID <= win.id;
            state  <= ST_SVC;
            INTR   <= 1'b0;
          end else if (!win.vld) begin
            state <= ST_IDLE;
            INTR  <= 1'b0;
          end
        end
        ST_SVC: begin
          if (EOI) state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
          INTR  <= 1'b0;
        end
      endcase
    end
  end

  assign PEND_OUT = pend;
  assign MASK_OUT = mask;

endmodule

// File: tb/tb_intr_controller.sv
// Bench for intr_controller: directed scenarios with literal expectations plus
// randomized traffic compared every cycle against a behavioural model.
module tb_intr_controller;

  localparam int N = 4;
  localparam logic [7:0] LIM = 8'h0F;

  logic         CLK = 1'b0;
  logic         RESET_N;
  logic [N-1:0] IRQ_IN;
  logic         MASK_WE;
  logic [7:0]   MASK_DATA;
  logic         INTR_ACK;
  logic         EOI;
  logic         INTR;
  logic [2:0]   SRC_ID;
  logic [7:0]   PEND_OUT;
  logic [7:0]   MASK_OUT;

  int errors = 0;
  int checks = 0;

  intr_controller #(.N_SRC(N)) dut (
    .CLK       (CLK),
    .RESET_N   (RESET_N),
    .IRQ_IN    (IRQ_IN),
    .MASK_WE   (MASK_WE),
    .MASK_DATA (MASK_DATA),
    .INTR_ACK  (INTR_ACK),
    .EOI       (EOI),
    .INTR      (INTR),
    .SRC_ID    (SRC_ID),
    .PEND_OUT  (PEND_OUT),
    .MASK_OUT  (MASK_OUT)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Behavioural model: a pending set, a mask, and two flags for
  // "request shown to the CPU" and "a source is being serviced".
  logic [7:0] m_pend, m_mask, m_prev;
  logic       m_req, m_busy;
  logic [2:0] m_id;

  function automatic int lowest(input logic [7:0] v);
    for (int i = 0; i < 8; i++) if (v[i]) return i;
    return -1;
  endfunction

  always @(posedge CLK or negedge RESET_N) begin : model
    logic [7:0] ev;
    logic [7:0] nxt;
    int w;
    if (!RESET_N) begin
      m_pend = '0; m_mask = '0; m_prev = '0;
      m_req = 1'b0; m_busy = 1'b0; m_id = '0;
    end else begin
      ev = '0;
      for (int i = 0; i < N; i++) if (IRQ_IN[i] && !m_prev[i]) ev[i] = 1'b1;
      w = lowest(m_pend & m_mask);
      nxt = m_pend;
      if (m_req) begin
        if (INTR_ACK && w >= 0) begin
          nxt[w] = 1'b0; m_id = w[2:0]; m_req = 1'b0; m_busy = 1'b1;
        end else if (w < 0) begin
          m_req = 1'b0;
        end
      end else if (m_busy) begin
        if (EOI) m_busy = 1'b0;
      end else if (w >= 0) begin
        m_req = 1'b1;
      end
      m_pend = nxt | ev;
      if (MASK_WE) m_mask = MASK_DATA & LIM;
      m_prev = '0;
      m_prev[N-1:0] = IRQ_IN;
    end
  end

  // Every-cycle comparison against the model, away from the rising edge.
  always @(negedge CLK) begin
    chk("model_intr", {31'd0, INTR}, {31'd0, m_req});
    chk("model_src_id", {29'd0, SRC_ID}, {29'd0, m_id});
    chk("model_pend", {24'd0, PEND_OUT}, {24'd0, m_pend});
    chk("model_mask", {24'd0, MASK_OUT}, {24'd0, m_mask});
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic write_mask(input logic [7:0] v);
    MASK_WE = 1'b1; MASK_DATA = v;
    tick();
    MASK_WE = 1'b0; MASK_DATA = 8'h00;
  endtask

  task automatic pulse_ack();
    INTR_ACK = 1'b1; tick(); INTR_ACK = 1'b0;
  endtask

  task automatic pulse_eoi();
    EOI = 1'b1; tick(); EOI = 1'b0;
  endtask

  initial begin
    RESET_N = 1'b0; IRQ_IN = '0; MASK_WE = 1'b0; MASK_DATA = 8'h00;
    INTR_ACK = 1'b0; EOI = 1'b0;
    repeat (3) tick();
    chk("rst_intr", {31'd0, INTR}, 32'd0);
    chk("rst_src", {29'd0, SRC_ID}, 32'd0);
    chk("rst_pend", {24'd0, PEND_OUT}, 32'd0);
    chk("rst_mask", {24'd0, MASK_OUT}, 32'd0);
    RESET_N = 1'b1;
    tick();

    // Single source
    write_mask(8'h04);
    chk("single_mask", {24'd0, MASK_OUT}, 32'h04);
    IRQ_IN = 4'b0100; tick();
    chk("single_pend", {24'd0, PEND_OUT}, 32'h04);
    chk("single_intr_lat1", {31'd0, INTR}, 32'd0);
    tick();
    chk("single_intr_lat2", {31'd0, INTR}, 32'd1);
    tick(); tick();
    chk("single_intr_hold", {31'd0, INTR}, 32'd1);
    pulse_ack();
    chk("single_ack_src", {29'd0, SRC_ID}, 32'd2);
    chk("single_ack_pend", {24'd0, PEND_OUT}, 32'h00);
    chk("single_ack_intr", {31'd0, INTR}, 32'd0);
    pulse_ack();
    chk("ack_in_svc_intr", {31'd0, INTR}, 32'd0);
    chk("ack_in_svc_src", {29'd0, SRC_ID}, 32'd2);
    chk("level_no_reevent", {24'd0, PEND_OUT}, 32'h00);
    pulse_eoi();
    tick();
    chk("single_eoi_intr", {31'd0, INTR}, 32'd0);
    pulse_eoi();
    tick();
    chk("eoi_in_idle_intr", {31'd0, INTR}, 32'd0);
    IRQ_IN = '0; tick();

    // Priority
    write_mask(8'h0F);
    IRQ_IN = 4'b1010; tick();
    chk("prio_pend", {24'd0, PEND_OUT}, 32'h0A);
    tick();
    chk("prio_intr", {31'd0, INTR}, 32'd1);
    pulse_ack();
    chk("prio_src1", {29'd0, SRC_ID}, 32'd1);
    chk("prio_pend_after1", {24'd0, PEND_OUT}, 32'h08);
    pulse_eoi();
    chk("prio_eoi_intr0", {31'd0, INTR}, 32'd0);
    tick();
    chk("prio_reassert", {31'd0, INTR}, 32'd1);
    pulse_ack();
    chk("prio_src3", {29'd0, SRC_ID}, 32'd3);
    chk("prio_pend_after2", {24'd0, PEND_OUT}, 32'h00);
    pulse_eoi();
    IRQ_IN = '0; tick();

    // Masking
    write_mask(8'h00);
    IRQ_IN = 4'b0001; tick();
    chk("mask_pend", {24'd0, PEND_OUT}, 32'h01);
    tick(); tick();
    chk("mask_intr_off", {31'd0, INTR}, 32'd0);
    write_mask(8'h01);
    chk("mask_en_intr0", {31'd0, INTR}, 32'd0);
    tick();
    chk("mask_en_intr1", {31'd0, INTR}, 32'd1);
    write_mask(8'h00);
    chk("mask_off_same", {31'd0, INTR}, 32'd1);
    tick();
    chk("mask_off_drop", {31'd0, INTR}, 32'd0);
    IRQ_IN = '0;

    // Collision: edge on source 1 in the same cycle as its grant
    write_mask(8'h02);
    IRQ_IN = 4'b0010; tick();
    IRQ_IN = 4'b0000; tick();
    chk("coll_intr", {31'd0, INTR}, 32'd1);
    IRQ_IN = 4'b0010; INTR_ACK = 1'b1; tick(); INTR_ACK = 1'b0;
    chk("coll_src", {29'd0, SRC_ID}, 32'd1);
    chk("coll_pend", {24'd0, PEND_OUT}, 32'h03);

    // Asynchronous reset while requesting
    pulse_eoi();
    tick();
    chk("arst_pre_intr", {31'd0, INTR}, 32'd1);
    #2 RESET_N = 1'b0;
    #1;
    chk("arst_intr", {31'd0, INTR}, 32'd0);
    chk("arst_pend", {24'd0, PEND_OUT}, 32'd0);
    chk("arst_mask", {24'd0, MASK_OUT}, 32'd0);
    chk("arst_src", {29'd0, SRC_ID}, 32'd0);
    IRQ_IN = '0;
    tick(); tick();
    RESET_N = 1'b1;
    write_mask(8'h0F);
    tick(); tick();
    chk("arst_no_intr", {31'd0, INTR}, 32'd0);

    // Randomized traffic
    for (int c = 0; c < 3000; c++) begin
      for (int b = 0; b < N; b++)
        if ($urandom_range(0, 5) == 0) IRQ_IN[b] = ~IRQ_IN[b];
      MASK_WE   = ($urandom_range(0, 15) == 0);
      MASK_DATA = 8'($urandom);
      INTR_ACK  = INTR ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 19) == 0);
      EOI       = ($urandom_range(0, 7) == 0);
      tick();
    end
    MASK_WE = 1'b0; INTR_ACK = 1'b0; EOI = 1'b0;
    tick(); tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/intr_controller.md
# intr_controller

Multi-source interrupt controller for the RAT MCU. Collects up to eight synchronous interrupt request lines, latches rising edges as pending, applies a software mask, and presents one INTR line to the control unit. On the control unit's interrupt-cycle acknowledge it records the winning source ID, readable on the IN port, and holds off further requests until software writes end-of-interrupt (EOI) through the OUT port.

## Interface
Parameters:
- N_SRC, 4, number of request lines; legal range 1..8

Ports:
- CLK  in  1  system clock; all state updates on its rising edge
- RESET_N  in  1  asynchronous, active-low reset
- IRQ_IN  in  N_SRC  request lines, already synchronous to CLK; rising edge = one event
- MASK_WE  in  1  one-cycle strobe; load MASK from MASK_DATA
- MASK_DATA  in  8  mask value from the OUT port bus; bit i = 1 enables source i; bits at or above N_SRC are ignored
- INTR_ACK  in  1  one-cycle pulse from the control unit while it is in its interrupt state
- EOI  in  1  one-cycle strobe from an OUT-port decode; ends service
- INTR  out  1  interrupt request to the control unit; registered
- SRC_ID  out  3  ID of the source granted at the last acknowledge; registered
- PEND_OUT  out  8  pending bits, zero-extended; for an IN-port status read
- MASK_OUT  out  8  current mask, zero-extended

## Operation
- Reset (RESET_N low, asynchronous): state ST_IDLE; INTR=0, SRC_ID=0, PEND=0, MASK=0 (all sources disabled), edge-history register=0. These values hold for as long as RESET_N is low.
- Edge detect: each source's event = IRQ_IN[i] & ~irq_d[i]. irq_d samples IRQ_IN every cycle.
- Pending: an event sets PEND[i] regardless of MASK. A bit is cleared only by grant.
- Mask: MASK_WE loads MASK_DATA[N_SRC-1:0].
- Arbitration: the candidate set is PEND & MASK. The lowest index has the highest priority.
- FSM states:
  - ST_IDLE: INTR=0. If the candidate set is non-zero, go to ST_REQ.
  - ST_REQ: INTR=1. If INTR_ACK: latch the winner into SRC_ID, clear PEND[winner], go to ST_SVC. Else, if the candidate set is zero (masked off before acknowledge), return to ST_IDLE.
  - ST_SVC: INTR=0. On EOI, go to ST_IDLE. New events keep accumulating in PEND.
- Simultaneous events:
  - An edge on the bit being cleared by grant in the same cycle: the set wins, so PEND stays 1.
  - MASK_WE coinciding with INTR_ACK: arbitration uses the old MASK.
  - INTR_ACK outside ST_REQ is ignored. EOI outside ST_SVC is ignored.
- No nesting: exactly one grant per EOI.

## Timing
- IRQ_IN rises before edge k, so PEND bit = 1 after edge k.
- If unmasked and in ST_IDLE, INTR = 1 after edge k+1. Edge-to-INTR latency is 2 cycles.
- INTR_ACK sampled at edge m gives INTR=0, SRC_ID valid and PEND bit cleared after edge m.
- EOI at edge n gives ST_IDLE after edge n. If the candidate set is non-empty, INTR re-asserts after edge n+1.
- INTR is a registered state decode with no combinational path from any input.
- PEND_OUT and MASK_OUT are direct register outputs.

## Structure
- Shared package rat_intc_pkg holds:
  - the state enum {ST_IDLE, ST_REQ, ST_SVC}
  - constant INTC_MAX_SRC=8
  - constant INTC_ID_W=3
  - the IN/OUT port-ID constants used to decode MASK_WE, EOI and status reads
- One sub-module, intc_edge_detect: the per-bit edge-history register and event output, parameterised on width.
- The priority encoder (lowest set index, with a valid flag) is a package function.

## Test plan
- Reset: RESET_N low mid-ST_REQ with INTR=1. All outputs go to 0 immediately (asynchronous). After release, there is no INTR until a new edge.
- Single source: MASK=0x04, IRQ_IN[2] rises at edge 10. PEND_OUT=0x04 after edge 10, INTR=1 after edge 11. ACK at edge 14 gives SRC_ID=2, PEND_OUT=0x00, INTR=0. EOI at edge 20 gives ST_IDLE with INTR staying 0.
- Priority: MASK=0x0F, edges on sources 3 and 1 in the same cycle. First ACK gives SRC_ID=1, PEND_OUT=0x08. After EOI, INTR re-asserts one cycle later. Second ACK gives SRC_ID=3.
- Masking: MASK=0x00, edge on source 0. PEND_OUT=0x01, INTR stays 0. Writing MASK=0x01 raises INTR 1 cycle later. Writing MASK=0x00 while in ST_REQ drops INTR the next cycle.
- Collisions: a new edge on source 1 in the same cycle as its ACK keeps PEND_OUT bit 1 = 1. A level held high on IRQ_IN produces no second event. ACK while in ST_SVC and EOI while in ST_IDLE change nothing.
